mem_bus_arbiter: RTL and testbench

- Owns the single external memory bus between the CPU datapath and an OAM DMA engine.
- A CPU write to register 0xFF46 starts a 160-byte copy from {src,8'h00}..{src,8'h9F} to 0xFE00..0xFE9F, one byte per machine cycle.
- While the copy runs, the CPU is restricted to HRAM (0xFF80..0xFFFE) and is stalled otherwise.
- Sits between the datapath's MAR/MDR bus interface and the memory/IO decoder.

---
 rtl/gb_mem_pkg.sv | 17 +
 rtl/oam_dma_engine.sv | 92 +++++++++
 rtl/mem_bus_arbiter.sv | 78 +++++++
 tb/tb_mem_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_mem_pkg.sv
// Shared types and address map for the memory bus arbiter and its OAM DMA engine.
package gb_mem_pkg;

    typedef enum logic [1:0] {DMA_IDLE, DMA_DELAY, DMA_XFER} dma_state_t;

    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  ECHO_HI_BYTE = 8'hE0;

    // Sources at or above the echo region are folded back onto work RAM.
    function automatic logic [7:0] dma_src_hi(input logic [7:0] r);
        return (r >= ECHO_HI_BYTE) ? r - 8'h20 : r;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: one M-cycle start delay, then one byte per M-cycle
// (read in phase 0, write in phase 2) from {src,idx} to OAM.
module oam_dma_engine #(
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          XFER_LEN        = 160,
    parameter logic [15:0] OAM_BASE        = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_val,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_re,
    output logic        dma_we,
    output logic        bus_busy,
    output logic        active,
    output logic [7:0]  dma_reg
);
    import gb_mem_pkg::*;

    localparam int            PW       = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0] PH_WRITE = PW'(2);
    localparam logic [7:0]    IDX_LAST = 8'(XFER_LEN - 1);

    dma_state_t    state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [7:0]    idx, idx_nx;
    logic [7:0]    dbuf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DMA_IDLE;
            phase   <= '0;
            idx     <= '0;
            dma_reg <= 8'h00;
            dbuf    <= 8'h00;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            idx   <= idx_nx;
            if (start)  dma_reg <= start_val;
            if (dma_re) dbuf    <= mem_rdata;
        end
    end

    // A register write always wins, so a write while active restarts cleanly.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        idx_nx   = idx;
        if (start) begin
            state_nx = DMA_DELAY;
            phase_nx = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                DMA_DELAY: begin
                    phase_nx = phase + 1'b1;
                    if (phase == PH_LAST) begin
                        state_nx = DMA_XFER;
                        phase_nx = '0;
                    end
                end
                DMA_XFER: begin
                    phase_nx = phase + 1'b1;
                    if (phase == PH_LAST) begin
                        phase_nx = '0;
                        idx_nx   = idx + 8'd1;
                        if (idx == IDX_LAST) begin
                            state_nx = DMA_IDLE;
                            idx_nx   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dma_re    = (state == DMA_XFER) && (phase == '0);
        dma_we    = (state == DMA_XFER) && (phase == PH_WRITE);
        dma_addr  = dma_we ? OAM_BASE + {8'h00, idx} : {dma_src_hi(dma_reg), idx};
        dma_wdata = dbuf;
        bus_busy  = dma_re | dma_we;
        active    = (state != DMA_IDLE);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the CPU and the OAM DMA engine;
// the CPU is stalled outside HRAM while a transfer runs.
module mem_bus_arbiter #(
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          XFER_LEN        = 160,
    parameter logic [15:0] OAM_BASE        = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_re,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);
    import gb_mem_pkg::*;

    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_reg;
    logic        dma_re, dma_we, bus_busy;
    logic        req, is_wr, is_rd, hit_reg, hit_hram, grant;

    // A combined read+write request is treated as a write.
    assign req      = cpu_re | cpu_we;
    assign is_wr    = cpu_we;
    assign is_rd    = cpu_re & ~cpu_we;
    assign hit_reg  = (cpu_addr == DMA_REG_ADDR);
    assign hit_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    assign grant    = req & ~hit_reg & (~dma_active | (hit_hram & ~bus_busy));

    oam_dma_engine #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .XFER_LEN        (XFER_LEN),
        .OAM_BASE        (OAM_BASE)
    ) u_dma (
        .clk       (clk),
        .rst       (rst),
        .start     (is_wr & hit_reg),
        .start_val (cpu_wdata),
        .mem_rdata (mem_rdata),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_re    (dma_re),
        .dma_we    (dma_we),
        .bus_busy  (bus_busy),
        .active    (dma_active),
        .dma_reg   (dma_reg)
    );

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        cpu_rdata = 8'hFF;
        cpu_stall = req & ~hit_reg & ~grant;
        if (bus_busy) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_re    = dma_re;
            mem_we    = dma_we;
        end else if (grant) begin
            mem_re = is_rd;
            mem_we = is_wr;
        end
        if (is_rd && hit_reg)    cpu_rdata = dma_reg;
        else if (is_rd && grant) cpu_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: memory model, cycle-level reference model of the
// DMA timeline and CPU arbitration, and directed scenarios with literal pins.
module tb_mem_bus_arbiter;
    localparam int CPB      = 4;
    localparam int LEN      = 160;
    localparam int ACT_CLKS = (1 + LEN) * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, mem_re, mem_we, dma_active;
    logic [15:0] mem_addr;

    logic [7:0] mem [0:65535];
    int  tests = 0, fails = 0;
    bit  started = 0;
    bit  m_active = 0;
    int  m_k = 0;
    logic [7:0] m_reg = 8'h00;
    int  rd_cnt = 0, wr_cnt = 0;
    int  n;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a[15:8])
            8'hC1:   return a[7:0] ^ 8'h5A;
            8'hC2:   return a[7:0] ^ 8'hA5;
            8'hC3:   return a[7:0] ^ 8'h3C;
            8'hFE:   return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // Memory side effects, then the reference model: the transfer is a
    // timeline of ACT_CLKS clocks counted from the register write.
    always @(posedge clk) begin
        if (!started) begin
            for (int a = 0; a < 65536; a++) mem[a] = init_byte(16'(a));
        end else if (mem_we) begin
            mem[mem_addr] = mem_wdata;
        end
        if (!rst) begin
            m_active = 0; m_k = 0; m_reg = 8'h00;
        end else if (cpu_we && cpu_addr == 16'hFF46) begin
            m_reg = cpu_wdata; m_active = 1; m_k = 0;
        end else if (m_active) begin
            if (m_k == ACT_CLKS - 1) m_active = 0;
            else m_k++;
        end
        started = 1;
    end

    always @(negedge clk) if (started) begin
        bit xfer, drd, dwr, req, wr, rd, hreg, hram, grant, stall;
        int b, ph;
        logic [7:0]  hi;
        logic [15:0] src;
        xfer  = m_active && m_k >= CPB;
        b     = xfer ? (m_k - CPB) / CPB : 0;
        ph    = xfer ? (m_k - CPB) % CPB : 0;
        drd   = xfer && ph == 0;
        dwr   = xfer && ph == 2;
        hi    = (m_reg >= 8'hE0) ? m_reg - 8'h20 : m_reg;
        src   = {hi, 8'(b)};
        req   = cpu_re || cpu_we;
        wr    = cpu_we;
        rd    = cpu_re && !cpu_we;
        hreg  = cpu_addr == 16'hFF46;
        hram  = cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE;
        grant = req && !hreg && (!m_active || (hram && !drd && !dwr));
        stall = req && !hreg && !grant;
        chk("dma_active", dma_active, m_active);
        chk("cpu_stall", cpu_stall, stall);
        chk("mem_re", mem_re, drd || (grant && rd));
        chk("mem_we", mem_we, dwr || (grant && wr));
        if (drd) chk("dma_rd_addr", mem_addr, src);
        else if (dwr) begin
            chk("dma_wr_addr", mem_addr, 16'hFE00 + 16'(b));
            chk("dma_wdata", mem_wdata, mem[src]);
        end else if (grant) begin
            chk("cpu_addr_fwd", mem_addr, cpu_addr);
            if (wr) chk("cpu_wdata_fwd", mem_wdata, cpu_wdata);
        end
        if (rd) chk("cpu_rdata", cpu_rdata, hreg ? m_reg : (grant ? mem[cpu_addr] : 8'hFF));
        else if (!req) chk("idle_rdata", cpu_rdata, 8'hFF);
        if (mem_re) rd_cnt++;
        if (mem_we) wr_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Leaves the bench in the first cycle after the write (timeline k=0).
    task automatic start_dma(input logic [7:0] v);
        set_req(1'b0, 1'b1, 16'hFF46, v);
        step();
        idle();
    endtask

    task automatic run(input int cyc);
        repeat (cyc) step();
    endtask

    task automatic wait_done(output int cnt);
        bit act;
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            act = dma_active;
            step();
            if (!act) return;
            cnt++;
        end
        chk("wait_done_timeout", 1, 0);
    endtask

    task automatic chk_oam(input string name, input int split, input logic [7:0] k_lo, input logic [7:0] k_hi);
        for (int i = 0; i < LEN; i++)
            chk(name, mem[16'hFE00 + 16'(i)], 8'(i) ^ ((i < split) ? k_lo : k_hi));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_active", dma_active, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_rdata", cpu_rdata, 8'hFF);
        step();
        set_req(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("rst_dma_reg", cpu_rdata, 8'h00);
        step();
        idle();
        run(2);

        // 1: plain copy from C100
        rd_cnt = 0; wr_cnt = 0;
        start_dma(8'hC1);
        wait_done(n);
        chk("t1_active_clks", n, ACT_CLKS);
        chk("t1_reads", rd_cnt, 160);
        chk("t1_writes", wr_cnt, 160);
        chk_oam("t1_oam", LEN, 8'h5A, 8'h5A);

        // 2: non-HRAM read stalls until the transfer ends
        start_dma(8'hC1);
        run(20);
        set_req(1'b1, 1'b0, 16'hC000, 8'h00);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!cpu_stall) break;
            n++;
            step();
        end
        chk("t2_stall_cycles", n, 624);
        chk("t2_grant_re", mem_re, 1);
        chk("t2_grant_addr", mem_addr, 16'hC000);
        chk("t2_active_fell", dma_active, 0);
        step();
        idle();
        run(2);

        // 3: HRAM access during delay and between DMA phases
        start_dma(8'hC1);
        run(2);
        set_req(1'b1, 1'b0, 16'hFF80, 8'h00);
        @(negedge clk);
        chk("t3_delay_stall", cpu_stall, 0);
        step();
        idle();
        run(42);
        set_req(1'b1, 1'b0, 16'hFF90, 8'h00);
        @(negedge clk);
        chk("t3_ph1_stall", cpu_stall, 0);
        chk("t3_ph1_addr", mem_addr, 16'hFF90);
        step();
        idle();
        step();
        set_req(1'b0, 1'b1, 16'hFF91, 8'h77);
        @(negedge clk);
        chk("t3_ph3_stall", cpu_stall, 0);
        chk("t3_ph3_we", mem_we, 1);
        step();
        set_req(1'b1, 1'b0, 16'hFF90, 8'h00);
        @(negedge clk);
        chk("t3_ph0_stall", cpu_stall, 1);
        chk("t3_ph0_dma_addr", mem_addr, 16'hC10B);
        step();
        @(negedge clk);
        chk("t3_retry_stall", cpu_stall, 0);
        chk("t3_retry_addr", mem_addr, 16'hFF90);
        step();
        idle();
        wait_done(n);

        // 4: restart from C200 at byte 50 of a D000 transfer
        start_dma(8'hD0);
        run(204);
        set_req(1'b0, 1'b1, 16'hFF46, 8'hC2);
        step();
        idle();
        wait_done(n);
        chk("t4_active_clks", n, ACT_CLKS);
        chk_oam("t4_oam", LEN, 8'hA5, 8'hA5);

        // 5: echo-region source and register readback while active
        start_dma(8'hE3);
        run(4);
        @(negedge clk);
        chk("t5_first_re", mem_re, 1);
        chk("t5_first_addr", mem_addr, 16'hC300);
        step();
        run(95);
        set_req(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("t5_reg_rdata", cpu_rdata, 8'hE3);
        chk("t5_reg_stall", cpu_stall, 0);
        step();
        idle();
        wait_done(n);
        chk_oam("t5_oam", LEN, 8'h3C, 8'h3C);

        // 6: reset at byte 80 aborts the copy
        start_dma(8'hC1);
        run(325);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_active", dma_active, 0);
        chk("t6_re", mem_re, 0);
        chk("t6_we", mem_we, 0);
        step();
        set_req(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        chk("t6_dma_reg", cpu_rdata, 8'h00);
        step();
        set_req(1'b1, 1'b0, 16'hC000, 8'h00);
        @(negedge clk);
        chk("t6_cpu_free", cpu_stall, 0);
        chk("t6_cpu_re", mem_re, 1);
        step();
        idle();
        run(3);
        chk_oam("t6_oam", 80, 8'h5A, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
